// File: rtl/trigger_source_select.sv
// Trigger source selector feeding the hold generator's TriggerIn.
// The asynchronous external and ASIC trigger lines are synchronised to Clk
// and edge-detected. A source is then picked or combined according to
// TrigMode. The block shapes the output pulse, enforces a dead time, and
// keeps accepted and lost trigger counters for slow control.
module trigger_source_select #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             Enable,
    input  logic [1:0]       TrigMode,
    input  logic [2:0]       AsicTrigMask,
    input  logic             ExtTrigger,
    input  logic [2:0]       AsicTrigger,
    input  logic             SoftTrigger,
    input  logic [7:0]       CoincWindow,
    input  logic [7:0]       PulseWidth,
    input  logic [15:0]      DeadTime,
    input  logic             CountClear,
    output logic             TriggerOut,
    output logic             Busy,
    output logic [CNT_W-1:0] TriggerCount,
    output logic [15:0]      LostCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COINC = 2'd1,
        PULSE = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_EXT   = 2'd0;
    localparam logic [1:0] MODE_ASIC  = 2'd1;
    localparam logic [1:0] MODE_COINC = 2'd2;

    // Synchroniser chains, delayed copies and registered one-cycle edges.
    logic [SYNC_STAGES-1:0]      ext_sync_q;
    logic                        ext_dly_q;
    logic                        ext_edge_q;
    logic [SYNC_STAGES-1:0][2:0] asic_sync_q;
    logic [2:0]                  asic_dly_q;
    logic [2:0]                  asic_edge_q;
    logic                        soft_q;

    // FSM state and the parameters latched when a trigger is taken.
    state_t                      state_q;
    logic                        trig_out_q;
    logic                        busy_q;
    logic [15:0]                 timer_q;
    logic [7:0]                  pw_q;
    logic [15:0]                 dt_q;
    logic [1:0]                  mode_q;
    logic                        side_ext_q;

    // Counters.
    logic [CNT_W-1:0]            trig_cnt_q;
    logic [CNT_W-1:0]            trig_cnt_d;
    logic [15:0]                 lost_cnt_q;
    logic [15:0]                 lost_cnt_d;

    // Combinational decode of the current cycle.
    logic                        ext_edge;
    logic                        asic_edge;
    logic                        fire_idle;
    logic                        coinc_start;
    logic                        coinc_hit;
    logic                        lost_edge;
    logic                        trig_inc;
    logic                        lost_inc;
    logic [7:0]                  pw_eff;

    // Synchronise the async inputs and register their rising edges.
    // The software strobe gets one register too, so it lines up with the edges.
    always_ff @(posedge Clk) begin
        if (reset) begin
            ext_sync_q  <= '0;
            ext_dly_q   <= 1'b0;
            ext_edge_q  <= 1'b0;
            asic_sync_q <= '0;
            asic_dly_q  <= '0;
            asic_edge_q <= '0;
            soft_q      <= 1'b0;
        end else begin
            ext_sync_q     <= {ext_sync_q[SYNC_STAGES-2:0], ExtTrigger};
            ext_dly_q      <= ext_sync_q[SYNC_STAGES-1];
            ext_edge_q     <= ext_sync_q[SYNC_STAGES-1] & ~ext_dly_q;
            asic_sync_q[0] <= AsicTrigger;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                asic_sync_q[k] <= asic_sync_q[k-1];
            end
            asic_dly_q  <= asic_sync_q[SYNC_STAGES-1];
            asic_edge_q <= asic_sync_q[SYNC_STAGES-1] & ~asic_dly_q;
            soft_q      <= SoftTrigger;
        end
    end

    // Decode the fire, coincidence and loss conditions and the counter next values.
    always_comb begin
        ext_edge    = ext_edge_q;
        asic_edge   = |(asic_edge_q & ~AsicTrigMask);
        fire_idle   = 1'b0;
        coinc_start = 1'b0;
        case (TrigMode)
            MODE_EXT:   fire_idle = ext_edge;
            MODE_ASIC:  fire_idle = asic_edge;
            MODE_COINC: begin
                fire_idle   = ext_edge & asic_edge;
                coinc_start = ext_edge ^ asic_edge;
            end
            default:    fire_idle = 1'b0;
        endcase
        // The software strobe fires directly in every mode.
        if (soft_q) begin
            fire_idle   = 1'b1;
            coinc_start = 1'b0;
        end

        // Only the side that has not yet arrived closes the coincidence.
        coinc_hit = soft_q
                  | ((side_ext_q ? asic_edge : ext_edge)
                     & (timer_q < {8'd0, CoincWindow}));

        // Edges that would have been used in the latched mode count as lost while busy.
        lost_edge = soft_q;
        case (mode_q)
            MODE_EXT:   lost_edge = soft_q | ext_edge;
            MODE_ASIC:  lost_edge = soft_q | asic_edge;
            MODE_COINC: lost_edge = soft_q | ext_edge | asic_edge;
            default:    lost_edge = soft_q;
        endcase

        trig_inc = Enable & (((state_q == IDLE) & fire_idle)
                           | ((state_q == COINC) & coinc_hit));
        lost_inc = Enable & busy_q & lost_edge;

        pw_eff = (PulseWidth == 8'd0) ? 8'd1 : PulseWidth;

        trig_cnt_d = trig_cnt_q;
        lost_cnt_d = lost_cnt_q;
        if (CountClear) begin
            trig_cnt_d = '0;
            lost_cnt_d = '0;
        end else begin
            if (trig_inc) begin
                trig_cnt_d = trig_cnt_q + CNT_W'(1);
            end
            if (lost_inc && (lost_cnt_q != 16'hFFFF)) begin
                lost_cnt_d = lost_cnt_q + 16'd1;
            end
        end
    end

    // Trigger FSM with registered TriggerOut and Busy.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= IDLE;
            trig_out_q <= 1'b0;
            busy_q     <= 1'b0;
            timer_q    <= '0;
            pw_q       <= 8'd1;
            dt_q       <= '0;
            mode_q     <= MODE_EXT;
            side_ext_q <= 1'b0;
        end else if (!Enable) begin
            state_q    <= IDLE;
            trig_out_q <= 1'b0;
            busy_q     <= 1'b0;
            timer_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire_idle) begin
                        state_q    <= PULSE;
                        trig_out_q <= 1'b1;
                        busy_q     <= 1'b1;
                        timer_q    <= '0;
                        pw_q       <= pw_eff;
                        mode_q     <= TrigMode;
                    end else if (coinc_start) begin
                        state_q    <= COINC;
                        timer_q    <= '0;
                        side_ext_q <= ext_edge;
                        mode_q     <= TrigMode;
                    end
                end
                COINC: begin
                    if (coinc_hit) begin
                        state_q    <= PULSE;
                        trig_out_q <= 1'b1;
                        busy_q     <= 1'b1;
                        timer_q    <= '0;
                        pw_q       <= pw_eff;
                    end else if (timer_q >= {8'd0, CoincWindow}) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                PULSE: begin
                    if (timer_q == ({8'd0, pw_q} - 16'd1)) begin
                        trig_out_q <= 1'b0;
                        timer_q    <= '0;
                        if (DeadTime != 16'd0) begin
                            state_q <= DEAD;
                            dt_q    <= DeadTime;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                DEAD: begin
                    if (timer_q == (dt_q - 16'd1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    trig_out_q <= 1'b0;
                    busy_q     <= 1'b0;
                    timer_q    <= '0;
                end
            endcase
        end
    end

    // Accepted and lost trigger counters.
    always_ff @(posedge Clk) begin
        if (reset) begin
            trig_cnt_q <= '0;
            lost_cnt_q <= '0;
        end else begin
            trig_cnt_q <= trig_cnt_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign TriggerOut   = trig_out_q;
    assign Busy         = busy_q;
    assign TriggerCount = trig_cnt_q;
    assign LostCount    = lost_cnt_q;

endmodule
